// File: rtl/datapath_mc.sv
// -----------------------------------------------------------------------------
// datapath_mc
//
// Multicycle register-to-register datapath with its own operand sequencer.
// A single start pulse reads Rn into A, then Rm into B (one register-file read
// port, so the two loads take separate cycles), shifts B, runs the ALU into C
// and the flags, then writes the selected source back to Rd.
// When vsel selects anything other than C, the load and execute stages are
// skipped and the operation goes straight to write-back.
//
// Parameters
//   WIDTH  data width of registers, ALU and immediates
//   NREGS  register-file depth (power of two), RW = $clog2(NREGS)
//   PCW    PC width, PCW <= WIDTH
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               request an operation (accepted only in IDLE)
//   rd, rn, rm          destination, A-source, B-source register numbers
//   shift               B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   alu_op              00 A+B, 01 A-B, 10 A&B, 11 ~B
//   vsel                write-back source: 00 C, 01 PC, 10 sximm8, 11 mdata
//   asel, bsel          force A to 0 / use sximm5 as B
//   set_flags, wb       update flags in EXEC / write Rd in WB
//   sximm8, sximm5      pre-extended immediates
//   mdata, PC           memory data, program counter
//   busy, done          operation in flight / one-cycle completion pulse
//   result, flags       C register, {V, N, Z}
//
// Build option
//   DATAPATH_MC_REGCLR_EN  when defined, reset also clears the register file;
//                          otherwise register contents persist across reset.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | waiting for start; fields latched on accept
// S_LOAD_A| A <- R[rn]
// S_LOAD_B| B <- R[rm]
// S_EXEC  | C <- ALU(Ain, Bin); flags if set_flags
// S_WB    | R[rd] <- vsel source if wb; done next cycle
// -----------------------------------------------------------------------------
module datapath_mc #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [$clog2(NREGS)-1:0] rn,
  input  logic [$clog2(NREGS)-1:0] rm,
  input  logic [1:0]               shift,
  input  logic [1:0]               alu_op,
  input  logic [1:0]               vsel,
  input  logic                     asel,
  input  logic                     bsel,
  input  logic                     set_flags,
  input  logic                     wb,
  input  logic [WIDTH-1:0]         sximm8,
  input  logic [WIDTH-1:0]         sximm5,
  input  logic [WIDTH-1:0]         mdata,
  input  logic [PCW-1:0]           PC,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [2:0]               flags
);

  localparam int RW  = $clog2(NREGS);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Operation fields captured at the accept edge
  logic [RW-1:0]    rd_q, rd_d;
  logic [RW-1:0]    rn_q, rn_d;
  logic [RW-1:0]    rm_q, rm_d;
  logic [1:0]       shift_q, shift_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [1:0]       vsel_q, vsel_d;
  logic             asel_q, asel_d;
  logic             bsel_q, bsel_d;
  logic             set_flags_q, set_flags_d;
  logic             wb_q, wb_d;
  logic [WIDTH-1:0] sximm5_q, sximm5_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [2:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [RW-1:0]    rf_raddr;
  logic [WIDTH-1:0] rf_rdata;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wdata;

  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic [WIDTH-1:0] pc_ext;

  // Single read port: B's address only in LOAD_B, A's otherwise
  assign rf_raddr = (state_q == S_LOAD_B) ? rm_q : rn_q;
  assign rf_rdata = regs_q[rf_raddr];

  // ---------------------------------------------------------------------------
  // Shifter and ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    b_sh = b_q;
    case (shift_q)
      2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[MSB:1]};
      2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
      default: b_sh = b_q;
    endcase

    ain = asel_q ? '0 : a_q;
    bin = bsel_q ? sximm5_q : b_sh;

    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op_q)
      2'b00: begin
        alu_res = ain + bin;
        alu_v   = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      2'b01: begin
        alu_res = ain - bin;
        alu_v   = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write-back source; mdata, PC and sximm8 are taken live in WB
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_ext          = '0;
    pc_ext[PCW-1:0] = PC;
    case (vsel_q)
      2'b00:   rf_wdata = c_q;
      2'b01:   rf_wdata = pc_ext;
      2'b10:   rf_wdata = sximm8;
      default: rf_wdata = mdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state and datapath register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    rn_d        = rn_q;
    rm_d        = rm_q;
    shift_d     = shift_q;
    alu_op_d    = alu_op_q;
    vsel_d      = vsel_q;
    asel_d      = asel_q;
    bsel_d      = bsel_q;
    set_flags_d = set_flags_q;
    wb_d        = wb_q;
    sximm5_d    = sximm5_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    rf_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_d        = rd;
          rn_d        = rn;
          rm_d        = rm;
          shift_d     = shift;
          alu_op_d    = alu_op;
          vsel_d      = vsel;
          asel_d      = asel;
          bsel_d      = bsel;
          set_flags_d = set_flags;
          wb_d        = wb;
          sximm5_d    = sximm5;
          state_d     = (vsel == 2'b00) ? S_LOAD_A : S_WB;
        end
      end
      S_LOAD_A: begin
        a_d     = rf_rdata;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_d     = rf_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d = alu_res;
        if (set_flags_q) begin
          flags_d = {alu_v, alu_res[MSB], (alu_res == '0)};
        end
        state_d = S_WB;
      end
      S_WB: begin
        rf_we   = wb_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      shift_q     <= '0;
      alu_op_q    <= '0;
      vsel_q      <= '0;
      asel_q      <= 1'b0;
      bsel_q      <= 1'b0;
      set_flags_q <= 1'b0;
      wb_q        <= 1'b0;
      sximm5_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      shift_q     <= shift_d;
      alu_op_q    <= alu_op_d;
      vsel_q      <= vsel_d;
      asel_q      <= asel_d;
      bsel_q      <= bsel_d;
      set_flags_q <= set_flags_d;
      wb_q        <= wb_d;
      sximm5_q    <= sximm5_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. A write pending in WB is dropped if reset is asserted in
  // that same cycle, so an aborted operation never reaches the file.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
`ifdef DATAPATH_MC_REGCLR_EN
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_we) begin
      regs_q[rd_q] <= rf_wdata;
    end
`else
    if (rst_n && rf_we) begin
      regs_q[rd_q] <= rf_wdata;
    end
`endif
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = c_q;
  assign flags  = flags_q;

endmodule
